// File: rtl/sc_rl_pkg.sv
// Shared definitions for the stochastic-computing RL blocks (unary decoder,
// Q-table and policy table).
//   fsm_state_e : decoder FSM states
//   NUM_ACT     : default number of action lanes
//   act_w()     : width of an action index for a given lane count
//   cnt_w()     : width of a counter that must hold 0..len without overflow
//   ACT_W       : action index width for the default lane count
package sc_rl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  localparam int NUM_ACT = 4;

  // A single lane still needs a 1-bit index so the ports never collapse to zero width.
  function automatic int act_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

  localparam int ACT_W = act_w(NUM_ACT);

endpackage

// File: rtl/unary_lane_counter.sv
// One action lane of the unary decoder: counts the 1-beats of its lane
// during a window.
//   clk, rst  : clock and synchronous active-high reset
//   clr       : clears the count (and the check state) at window start
//   en        : a beat is being accepted this cycle
//   lane_bit  : this lane's unary bit for the beat
//   count     : number of accepted 1-beats so far
//   err       : (UNARY_CHECK_EN only) a 1 arrived after a 0 in this window
// Optional feature macro: UNARY_CHECK_EN enables the thermometer check.
module unary_lane_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             lane_bit,
  output logic [CNT_W-1:0] count
`ifdef UNARY_CHECK_EN
  ,
  output logic             err
`endif
);

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && lane_bit) begin
      count <= count + CNT_W'(1);
    end
  end

`ifdef UNARY_CHECK_EN
  logic seen_zero;

  // A thermometer stream is all 1s then all 0s; a 1 after any 0 is illegal.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seen_zero <= 1'b0;
      err       <= 1'b0;
    end else if (en) begin
      if (!lane_bit) begin
        seen_zero <= 1'b1;
      end else if (seen_zero) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/unary_argmax_decoder.sv
// Decodes a window of WIN_LEN unary beats across NUM_ACT action lanes into
// the maximum Q-value and its argmax action, then writes the action into
// the policy table at the state address captured with i_start.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_start, i_state   : begin a window and capture the state address
//   i_valid, i_bits    : one beat, one unary bit per action lane
//   i_ready            : consumer takes the result
//   o_busy, o_valid    : window in progress / result available
//   o_max, o_action    : decoded maximum and argmax lane (lowest index on ties)
//   o_addr_w, o_write_en, o_data : policy-table write port (one pulse per window)
//   o_err              : (UNARY_CHECK_EN only) non-thermometer stream seen
// Optional feature macro: UNARY_CHECK_EN.
module unary_argmax_decoder #(
  parameter  int WIN_LEN  = 16,
  parameter  int ADDR_W   = 4,
  parameter  int NUM_ACT  = sc_rl_pkg::NUM_ACT,
  localparam int CNT_W    = sc_rl_pkg::cnt_w(WIN_LEN),
  localparam int ACTION_W = sc_rl_pkg::act_w(NUM_ACT)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_state,
  input  logic                i_valid,
  input  logic [NUM_ACT-1:0]  i_bits,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_valid,
  output logic [CNT_W-1:0]    o_max,
  output logic [ACTION_W-1:0] o_action,
  output logic [ADDR_W-1:0]   o_addr_w,
  output logic                o_write_en,
  output logic [ACTION_W-1:0] o_data
`ifdef UNARY_CHECK_EN
  ,
  output logic                o_err
`endif
);

  import sc_rl_pkg::*;

  fsm_state_e state, state_nxt;

  logic                start_win;
  logic                beat;
  logic                last_beat;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    or_cnt;
  logic [CNT_W-1:0]    or_nxt;
  logic [CNT_W-1:0]    lane_cnt [NUM_ACT];
  logic [CNT_W-1:0]    lane_nxt [NUM_ACT];
  logic [CNT_W-1:0]    best_cnt;
  logic [ACTION_W-1:0] best_idx;

  assign start_win = (state == ST_IDLE) && i_start;
  assign beat      = (state == ST_ACC) && i_valid;
  assign last_beat = beat && (beat_cnt == CNT_W'(WIN_LEN - 1));

`ifdef UNARY_CHECK_EN
  logic [NUM_ACT-1:0] lane_err;
  assign o_err = |lane_err;
`endif

  for (genvar k = 0; k < NUM_ACT; k++) begin : g_lane
    unary_lane_counter #(.CNT_W(CNT_W)) u_lane (
      .clk      (i_clk),
      .rst      (i_rst),
      .clr      (start_win),
      .en       (beat),
      .lane_bit (i_bits[k]),
      .count    (lane_cnt[k])
`ifdef UNARY_CHECK_EN
      ,
      .err      (lane_err[k])
`endif
    );
    // Results are registered on the last beat, so they must include it.
    assign lane_nxt[k] = lane_cnt[k] + CNT_W'(i_bits[k]);
  end

  assign or_nxt = or_cnt + CNT_W'(|i_bits);

  // Strict '>' keeps the lowest index on ties and gives 0 when all are 0.
  always_comb begin
    best_cnt = lane_nxt[0];
    best_idx = '0;
    for (int k = 1; k < NUM_ACT; k++) begin
      if (lane_nxt[k] > best_cnt) begin
        best_cnt = lane_nxt[k];
        best_idx = ACTION_W'(k);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_valid   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        o_busy = 1'b1;
        if (last_beat) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      beat_cnt   <= '0;
      or_cnt     <= '0;
      o_max      <= '0;
      o_action   <= '0;
      o_data     <= '0;
      o_addr_w   <= '0;
      o_write_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      // The pulse lands on the first DONE cycle only.
      o_write_en <= last_beat;
      if (start_win) begin
        addr_q   <= i_state;
        beat_cnt <= '0;
        or_cnt   <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        or_cnt   <= or_nxt;
      end
      if (last_beat) begin
        o_max    <= or_nxt;
        o_action <= best_idx;
        o_data   <= best_idx;
        o_addr_w <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_unary_argmax_decoder.sv
// Randomised self-checking bench for unary_argmax_decoder. Expected results
// come from a window-level model: per-lane popcounts, count of non-zero
// beats, argmax with lowest-index tie break, and a "1 after 0" rule per lane.
module tb_unary_argmax_decoder;

  localparam int WIN_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_ACT = 4;
  localparam int CNT_W   = $clog2(WIN_LEN + 1);
  localparam int ACT_W   = $clog2(NUM_ACT);

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [ADDR_W-1:0]  i_state;
  logic               i_valid;
  logic [NUM_ACT-1:0] i_bits;
  logic               i_ready;
  logic               o_busy;
  logic               o_valid;
  logic [CNT_W-1:0]   o_max;
  logic [ACT_W-1:0]   o_action;
  logic [ADDR_W-1:0]  o_addr_w;
  logic               o_write_en;
  logic [ACT_W-1:0]   o_data;
`ifdef UNARY_CHECK_EN
  logic               o_err;
`endif

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;

  logic [NUM_ACT-1:0] beats [WIN_LEN];

  unary_argmax_decoder #(
    .WIN_LEN (WIN_LEN),
    .ADDR_W  (ADDR_W),
    .NUM_ACT (NUM_ACT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_state    (i_state),
    .i_valid    (i_valid),
    .i_bits     (i_bits),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_max      (o_max),
    .o_action   (o_action),
    .o_addr_w   (o_addr_w),
    .o_write_en (o_write_en),
    .o_data     (o_data)
`ifdef UNARY_CHECK_EN
    ,
    .o_err      (o_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_write_en) wr_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_thermo(input int v0, input int v1, input int v2, input int v3);
    int vals [NUM_ACT];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int b = 0; b < WIN_LEN; b++)
      for (int k = 0; k < NUM_ACT; k++)
        beats[b][k] = (b < vals[k]);
  endtask

  task automatic model(output int exp_max, output int exp_act, output bit exp_err);
    int cnt [NUM_ACT];
    exp_max = 0;
    exp_act = 0;
    exp_err = 1'b0;
    for (int k = 0; k < NUM_ACT; k++) cnt[k] = 0;
    for (int b = 0; b < WIN_LEN; b++) begin
      if (beats[b] != '0) exp_max++;
      for (int k = 0; k < NUM_ACT; k++) cnt[k] += int'(beats[b][k]);
    end
    for (int k = 1; k < NUM_ACT; k++)
      if (cnt[k] > cnt[exp_act]) exp_act = k;
    // Not thermometer: some lane has a 0 at beat i and a 1 at a later beat j.
    for (int k = 0; k < NUM_ACT; k++)
      for (int i = 0; i < WIN_LEN; i++)
        for (int j = i + 1; j < WIN_LEN; j++)
          if (!beats[i][k] && beats[j][k]) exp_err = 1'b1;
  endtask

  task automatic run_window(input logic [ADDR_W-1:0] st, input int valid_pct, input int ready_wait);
    int em, ea, wr0, cyc, b;
    bit ee;
    model(em, ea, ee);
    wr0 = wr_count;
    i_state = st;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_state = ADDR_W'($urandom);
    check("busy_in_acc", o_busy, 1);
    b = 0;
    cyc = 0;
    while (b < WIN_LEN && cyc < 20 * WIN_LEN) begin
      if (int'($urandom_range(99)) < valid_pct) begin
        i_valid = 1'b1;
        i_bits  = beats[b];
        b++;
      end else begin
        i_valid = 1'b0;
        i_bits  = NUM_ACT'($urandom);
      end
      i_start = 1'($urandom_range(1));
      i_ready = 1'($urandom_range(1));
      step();
      cyc++;
      if (b < WIN_LEN && o_valid) check("early_valid", o_valid, 0);
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    check("beats_accepted", b, WIN_LEN);
    if (valid_pct >= 100) check("latency", cyc, WIN_LEN);
    check("valid_first_done", o_valid, 1);
    check("write_en_first_done", o_write_en, 1);
    check("max", o_max, em);
    check("action", o_action, ea);
    check("addr_w", o_addr_w, st);
    check("data", o_data, ea);
`ifdef UNARY_CHECK_EN
    check("err", o_err, ee);
`endif
    for (int w = 0; w < ready_wait; w++) begin
      i_ready = 1'b0;
      step();
      check("valid_hold", o_valid, 1);
      check("write_en_single", o_write_en, 0);
      check("max_hold", o_max, em);
      check("action_hold", o_action, ea);
      check("addr_hold", o_addr_w, st);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("idle_valid", o_valid, 0);
    check("idle_busy", o_busy, 0);
    check("write_pulses", wr_count - wr0, 1);
  endtask

  task automatic random_beats(input bit thermo);
    if (thermo)
      set_thermo($urandom_range(WIN_LEN), $urandom_range(WIN_LEN),
                 $urandom_range(WIN_LEN), $urandom_range(WIN_LEN));
    else
      for (int b = 0; b < WIN_LEN; b++) beats[b] = NUM_ACT'($urandom);
  endtask

  initial begin
    int wr0;
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_state = '1;
    i_valid = 1'b1;
    i_bits  = '1;
    i_ready = 1'b1;
    step();
    step();
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_write_en", o_write_en, 0);
    check("rst_max", o_max, 0);
    check("rst_action", o_action, 0);
    check("rst_addr", o_addr_w, 0);
    check("rst_data", o_data, 0);
`ifdef UNARY_CHECK_EN
    check("rst_err", o_err, 0);
`endif
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_bits  = '0;
    i_ready = 1'b0;
    step();

    // Ties between lanes 1 and 3 resolve to lane 1.
    set_thermo(5, 9, 3, 9);
    run_window(4'd7, 100, 0);

    set_thermo(0, 0, 0, 0);
    run_window(4'd10, 100, 1);

    set_thermo(0, 0, 0, 16);
    run_window(4'd2, 100, 0);

    random_beats(1'b1);
    run_window(4'd5, 50, 5);

    // Reset in the middle of a window, with every other input active.
    set_thermo(12, 4, 8, 15);
    i_state = 4'd3;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      i_valid = 1'b1;
      i_bits  = beats[b];
      step();
    end
    wr0 = wr_count;
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_ready = 1'b1;
    step();
    check("abort_busy", o_busy, 0);
    check("abort_valid", o_valid, 0);
    check("abort_write_en", o_write_en, 0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("abort_idle", o_busy, 0);
    check("abort_no_write", wr_count - wr0, 0);
    set_thermo(12, 4, 8, 15);
    run_window(4'd9, 100, 0);

`ifdef UNARY_CHECK_EN
    set_thermo(3, 6, 0, 2);
    for (int b = 0; b < WIN_LEN; b++) beats[b][2] = (b % 2 == 0);
    run_window(4'd1, 100, 2);
    set_thermo(3, 6, 10, 2);
    run_window(4'd1, 100, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      random_beats(1'($urandom_range(1)));
      run_window(ADDR_W'($urandom), int'($urandom_range(100, 30)), int'($urandom_range(3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
